mac_stream_fix8bx2: RTL and testbench
=====================================

// Module: mac_stream_fix8bx2
// PURPOSE
//  Flow-controlled producer/consumer around a 2-lane signed 8-bit multiply-add.
//  - Accepts element pairs over the library ivalid/oready handshake.
//  - Computes a0*b0 + a1*b1 in an internal LAT-stage pipeline.
//  - Accumulates VEC_LEN products into one 32-bit dot product.
//  - Returns each dot product over ovalid/iready, with real backpressure.
//  Sits between the conv-layer data feeder and the output writer.
//  Replaces the always-ready usage of the stall-free multiply-add.
// PARAMETERS
//  LAT         3   multiply-add pipeline depth, in cycles (>=1)
//  VEC_LEN     16  elements per dot product (>=1)
//  FIFO_DEPTH  4   result FIFO entries (power of 2, >=2)
// PORTS
//  clock    in   1   single clock; all logic on its rising edge
//  reset    in   1   synchronous, active-high
//  ivalid   in   1   upstream element valid
//  oready   out  1   this block can accept an element
//  dataa_0  in   8   signed lane-0 operand a
//  datab_0  in   8   signed lane-0 operand b
//  dataa_1  in   8   signed lane-1 operand a
//  datab_1  in   8   signed lane-1 operand b
//  ovalid   out  1   result valid to downstream
//  iready   in   1   downstream accepts the result
//  result   out  32  signed dot product (FIFO head)
// BEHAVIOUR
//  Reset (synchronous, active-high)
//  - Outputs: ovalid=0, oready=1, result=0.
//  - Clears elem_cnt, acc, reserved and the FIFO pointers.
//  - Clears all pipeline valid/last tags; in-flight elements are discarded.
//  - A partial vector is dropped. Reset wins over every other event.
//  Input handshake
//  - An element is accepted in a cycle where ivalid && oready.
//  - Operands are sampled only on acceptance; ivalid gaps are legal.
//  - elem_cnt counts accepted elements 0..VEC_LEN-1 and wraps to 0.
//  - The last element is the one accepted with elem_cnt==VEC_LEN-1.
//  Credit control
//  - reserved = FIFO entries + closed vectors not yet written to the FIFO.
//  - reserved increments on accepting a last element.
//  - reserved decrements on the output handshake (ovalid && iready).
//  - If both happen in the same cycle, reserved is unchanged.
//  - oready = (elem_cnt != VEC_LEN-1) || (reserved < FIFO_DEPTH).
//  - oready is a combinational function of registered state; it does not
//    depend on ivalid.
//  - Result: the pipeline never stalls and the FIFO never overflows.
//  Arithmetic
//  - Product p = a0*b0 + a1*b1, signed, 17 bits; range -32512..32768.
//  - p is sign-extended to 32 bits. acc is 32 bits, two's complement.
//  - acc wraps silently on overflow; there is no saturation.
//  Pipeline timing
//  - Element accepted at cycle t emerges with its valid/last tags at t+LAT.
//  - At the emerge cycle, for a non-last element: acc <= acc + p.
//  - For a last element: push acc+p into the FIFO and set acc <= 0.
//  - So the next vector starts from 0 with no bubble.
//  - VEC_LEN=1: every element is last, and the FIFO value is p.
//  Output side
//  - ovalid = FIFO not empty; result = FIFO head.
//  - result holds its value while ovalid && !iready.
//  - Pop on ovalid && iready. Push and pop may occur in the same cycle.
//  - Latency: a last element accepted at t gives ovalid=1 at t+LAT+1
//    when the FIFO was empty.
//  - Results leave in vector order. When the FIFO is empty, result shows the
//    last-read entry (0 after reset).
// TESTING
//  1. VEC_LEN=16, 16 elements all operands 1, iready=1
//     -> one result 0x00000020 at t_last+LAT+1.
//  2. a0=b0=a1=b1=-128 x16 -> 0x00080000.
//     a0=-128, b0=127, a1=b1=0 x16 -> 0xFFFC0800.
//  3. iready=0, stream 5 vectors back-to-back
//     -> oready drops at the 5th last element; 4 results are held.
//     Then release iready -> results in order; the 5th vector completes.
//  4. Random ivalid/iready at 50% for 1000 vectors vs reference model
//     -> all match, no loss or duplication. Accept and pop in the same cycle
//     at reserved==FIFO_DEPTH -> reserved stays FIFO_DEPTH.
//  5. Reset asserted with elem_cnt=7 and 2 elements in flight
//     -> next cycle ovalid=0, oready=1. The next 16 elements give a clean
//     sum with no residue.
//  6. VEC_LEN=1, LAT=1: a0=3, b0=-5, a1=2, b1=4 on every cycle, iready=1
//     -> 0xFFFFFFF9 on every cycle after 2-cycle latency, oready held 1.

Source files
------------

// File: rtl/mac_stream_fix8bx2.sv
// mac_stream_fix8bx2: flow-controlled 2-lane int8 multiply-add with dot-product accumulation and result FIFO
module mac_stream_fix8bx2 #(
  parameter int LAT        = 3,
  parameter int VEC_LEN    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ivalid,
  output logic        oready,
  input  logic [7:0]  dataa_0,
  input  logic [7:0]  datab_0,
  input  logic [7:0]  dataa_1,
  input  logic [7:0]  datab_1,
  output logic        ovalid,
  input  logic        iready,
  output logic [31:0] result
);
  localparam int CW = VEC_LEN > 1 ? $clog2(VEC_LEN) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST  = CW'(VEC_LEN - 1);
  localparam logic [AW:0]   DEPTH = (AW + 1)'(FIFO_DEPTH);
  logic [CW-1:0]        r_elem_cnt;
  logic [AW:0]          r_reserved, r_wr, r_rd;
  logic [31:0]          r_acc, r_last;
  logic [31:0]          r_mem [FIFO_DEPTH];
  logic signed [16:0]   r_p [LAT];
  logic [LAT-1:0]       r_v, r_l;
  logic signed [7:0]    w_a0, w_b0, w_a1, w_b1;
  logic signed [15:0]   w_m0, w_m1;
  logic signed [16:0]   w_p;
  logic [31:0]          w_px, w_sum;
  logic                 w_last_elem, w_acc, w_inc, w_pop, w_push, w_empty;
  assign w_a0 = dataa_0;
  assign w_b0 = datab_0;
  assign w_a1 = dataa_1;
  assign w_b1 = datab_1;
  assign w_m0 = w_a0 * w_b0;
  assign w_m1 = w_a1 * w_b1;
  assign w_p  = {w_m0[15], w_m0} + {w_m1[15], w_m1};
  assign w_last_elem = r_elem_cnt == LAST;
  // A last element reserves a FIFO slot up front, so the pipeline never has to stall
  assign oready  = !w_last_elem || (r_reserved < DEPTH);
  assign w_acc   = ivalid && oready;
  assign w_inc   = w_acc && w_last_elem;
  assign w_empty = r_wr == r_rd;
  assign ovalid  = !w_empty;
  assign w_pop   = ovalid && iready;
  assign w_push  = r_v[LAT-1] && r_l[LAT-1];
  assign w_px    = {{15{r_p[LAT-1][16]}}, r_p[LAT-1]};
  assign w_sum   = r_acc + w_px;
  assign result  = w_empty ? r_last : r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clock) begin
    r_p[0] <= w_p;
    for (int i = 1; i < LAT; i++) r_p[i] <= r_p[i-1];
    if (w_push) r_mem[r_wr[AW-1:0]] <= w_sum;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_elem_cnt <= '0;
      r_acc      <= '0;
      r_reserved <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_last     <= '0;
      r_v        <= '0;
      r_l        <= '0;
    end else begin
      if (w_acc) r_elem_cnt <= w_last_elem ? '0 : r_elem_cnt + 1'b1;
      r_reserved <= (w_inc && !w_pop) ? r_reserved + 1'b1 :
                    (!w_inc && w_pop) ? r_reserved - 1'b1 : r_reserved;
      r_v[0] <= w_acc;
      r_l[0] <= w_inc;
      for (int i = 1; i < LAT; i++) begin
        r_v[i] <= r_v[i-1];
        r_l[i] <= r_l[i-1];
      end
      if (r_v[LAT-1]) r_acc <= r_l[LAT-1] ? '0 : w_sum;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) begin
        r_last <= result;
        r_rd   <= r_rd + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mac_stream_fix8bx2.sv
// tb_mac_stream_fix8bx2: directed and random checks of the streaming dot-product MAC against a scoreboard
module tb_mac_stream_fix8bx2;
  logic        clock = 0, reset = 1;
  logic        ivalid = 0, iready = 0, ivalid6 = 0;
  logic [7:0]  dataa_0 = 0, datab_0 = 0, dataa_1 = 0, datab_1 = 0;
  logic        oready, ovalid, oready6, ovalid6;
  logic [31:0] result, result6, last_pop = 0;
  int          n_chk = 0, n_fail = 0, n_pop = 0, n_acc = 0, macc = 0, mcnt = 0;
  int          q[$];
  mac_stream_fix8bx2 #(.LAT(3), .VEC_LEN(16), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .ivalid(ivalid), .oready(oready),
    .dataa_0(dataa_0), .datab_0(datab_0), .dataa_1(dataa_1), .datab_1(datab_1),
    .ovalid(ovalid), .iready(iready), .result(result));
  mac_stream_fix8bx2 #(.LAT(1), .VEC_LEN(1), .FIFO_DEPTH(4)) u6 (
    .clock(clock), .reset(reset), .ivalid(ivalid6), .oready(oready6),
    .dataa_0(8'd3), .datab_0(8'hFB), .dataa_1(8'd2), .datab_1(8'd4),
    .ovalid(ovalid6), .iready(1'b1), .result(result6));
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Scoreboard: handshakes are judged half a cycle before the edge that commits them
  always @(negedge clock) begin
    #1;
    if (reset) begin
      q.delete();
      macc = 0;
      mcnt = 0;
    end else begin
      if (ovalid && iready) begin
        if (q.size() == 0) check("pop_unexpected", q.size(), 1);
        else check("result_order", result, q.pop_front());
        last_pop = result;
        n_pop++;
      end
      if (ivalid && oready) begin
        macc += $signed(dataa_0) * $signed(datab_0) + $signed(dataa_1) * $signed(datab_1);
        n_acc++;
        if (mcnt == 15) begin
          q.push_back(macc);
          macc = 0;
          mcnt = 0;
        end else mcnt++;
      end
    end
  end
  task automatic wait_acc();
    int n = 0;
    #1;
    while (!oready && n < 200) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (!oready) check("accept_timeout", oready, 1);
  endtask
  task automatic send(input int a0, input int b0, input int a1, input int b1);
    @(negedge clock);
    ivalid = 1;
    dataa_0 = 8'(a0);
    datab_0 = 8'(b0);
    dataa_1 = 8'(a1);
    datab_1 = 8'(b1);
    wait_acc();
  endtask
  task automatic idle(input int n);
    @(negedge clock);
    ivalid = 0;
    repeat (n - 1) @(negedge clock);
  endtask
  initial begin
    int n, p0, c;
    repeat (3) @(negedge clock);
    reset = 0;
    iready = 1;
    #1;
    check("rst_ovalid", ovalid, 0);
    check("rst_oready", oready, 1);
    check("rst_result", result, 0);
    repeat (16) send(1, 1, 1, 1);
    @(negedge clock);
    ivalid = 0;
    n = 1;
    #1;
    while (!ovalid && n < 20) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("t1_latency", n, 4);
    idle(3);
    check("t1_value", last_pop, 32'h20);
    repeat (16) send(-128, -128, -128, -128);
    idle(8);
    check("t2_neg_sq", last_pop, 32'h00080000);
    repeat (16) send(-128, 127, 0, 0);
    idle(8);
    check("t2_mixed", last_pop, 32'hFFFC0800);
    p0 = n_pop;
    @(negedge clock);
    iready = 0;
    for (int v = 0; v < 5; v++)
      for (int e = 0; e < 16; e++)
        if (v < 4 || e < 15) send(v + 1, e, 0, 0);
    @(negedge clock);
    ivalid = 1;
    dataa_0 = 8'd5;
    datab_0 = 8'd15;
    #1;
    check("t3_blocked", oready, 0);
    check("t3_ovalid", ovalid, 1);
    check("t3_head", result, 120);
    repeat (5) @(negedge clock);
    #1;
    check("t3_still_blocked", oready, 0);
    check("t3_hold", result, 120);
    @(negedge clock);
    iready = 1;
    wait_acc();
    idle(12);
    check("t3_pops", n_pop - p0, 5);
    check("t3_fifth", last_pop, 600);
    p0 = n_pop;
    n = n_acc;
    c = 0;
    while (n_acc - n < 16000 && c < 45000) begin
      @(negedge clock);
      ivalid = 1'($urandom_range(0, 1));
      iready = 1'($urandom_range(0, 1));
      dataa_0 = 8'($urandom);
      datab_0 = 8'($urandom);
      dataa_1 = 8'($urandom);
      datab_1 = 8'($urandom);
      #2;
      c++;
    end
    @(negedge clock);
    ivalid = 0;
    iready = 1;
    repeat (20) @(negedge clock);
    check("t4_vectors", n_pop - p0, 1000);
    check("t4_drained", q.size(), 0);
    @(negedge clock);
    iready = 0;
    repeat (16) send(1, 1, 1, 1);
    repeat (7) send(1, 1, 1, 1);
    @(negedge clock);
    ivalid = 0;
    #1;
    check("t5_pending", ovalid, 1);
    reset = 1;
    @(negedge clock);
    reset = 0;
    #1;
    check("t5_ovalid", ovalid, 0);
    check("t5_oready", oready, 1);
    check("t5_result", result, 0);
    iready = 1;
    p0 = n_pop;
    repeat (16) send(2, 2, 0, 0);
    idle(8);
    check("t5_clean", last_pop, 64);
    check("t5_pops", n_pop - p0, 1);
    @(negedge clock);
    ivalid6 = 1;
    #1;
    check("t6_oready", oready6, 1);
    check("t6_ovalid0", ovalid6, 0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      #1;
      check("t6_oready", oready6, 1);
      check("t6_ovalid", ovalid6, k >= 2);
      if (k >= 2) check("t6_result", result6, 32'hFFFFFFF9);
    end
    ivalid6 = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
